// File: rtl/muxn_rr_stream_pkg.sv
// muxn_pkg: shared defaults and helpers for the muxn_rr_stream slice.
package muxn_pkg;

    localparam int N_DEF = 4;
    localparam int W_DEF = 64;

    // Width of a channel index; stays 1 for a single channel so ports never collapse to zero bits.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // LSB of channel i in a flat bus of w-bit lanes: bus[ch_lsb(i, w) +: w].
    function automatic int ch_lsb(input int i, input int w);
        return i * w;
    endfunction

endpackage

// File: rtl/muxn_rr_stream_if.sv
// muxn_rr_stream_if: N producer lanes in, one registered consumer stream out.
interface muxn_rr_stream_if
    import muxn_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = W_DEF
);
    localparam int SEL_W = clog2_min1(N);

    logic [N-1:0]     in_valid;
    logic [N*W-1:0]   in_data;
    logic [N-1:0]     in_ready;
    logic             out_valid;
    logic [W-1:0]     out_data;
    logic [SEL_W-1:0] out_sel;
    logic             out_ready;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );

endinterface

// File: rtl/muxn_rr_stream_arb.sv
// muxn_rr_arb: round-robin arbiter owning the priority pointer.
// MUXN_FIXED_PRIO_EN: lowest-index fixed priority, no pointer.
module muxn_rr_arb
    import muxn_pkg::*;
#(
    parameter  int N     = N_DEF,
    localparam int SEL_W = clog2_min1(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [N-1:0]     gnt_onehot,
    output logic [SEL_W-1:0] gnt_idx
);
    logic found;

`ifdef MUXN_FIXED_PRIO_EN
    logic unused;
    assign unused = ^{clk, rst, advance};

    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < N; k++) begin
            if (!found && req[k]) begin
                found   = 1'b1;
                gnt_idx = SEL_W'(k);
            end
        end
    end
`else
    logic [SEL_W-1:0] ptr_q, ptr_d;
    int               j;

    // Scan starts at ptr and wraps, so the channel just served drops to last priority.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        j       = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr_q) + k) % N;
            if (!found && req[j]) begin
                found   = 1'b1;
                gnt_idx = SEL_W'(j);
            end
        end
        ptr_d = advance ? ((gnt_idx == SEL_W'(N - 1)) ? '0 : gnt_idx + SEL_W'(1)) : ptr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end
`endif

    assign gnt_onehot = found ? (N'(1) << gnt_idx) : '0;

endmodule

// File: rtl/muxn_rr_stream.sv
// muxn_rr_stream: N-to-1 registered stream mux, 1-cycle latency, full throughput.
// MUXN_FIXED_PRIO_EN selects fixed priority in the arbiter instead of round-robin.
module muxn_rr_stream
    import muxn_pkg::*;
#(
    parameter  int N     = N_DEF,
    parameter  int W     = W_DEF,
    localparam int SEL_W = clog2_min1(N)
) (
    input  logic              clk,
    input  logic              rst,
    muxn_rr_stream_if.slave   bus
);
    logic             load, any_v, xfer;
    logic [N-1:0]     gnt;
    logic [SEL_W-1:0] gnt_idx;
    logic [W-1:0]     sel_data;
    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     out_data_q, out_data_d;
    logic [SEL_W-1:0] out_sel_q, out_sel_d;

    muxn_rr_arb #(.N(N)) u_arb (
        .clk        (clk),
        .rst        (rst),
        .req        (bus.in_valid),
        .advance    (xfer),
        .gnt_onehot (gnt),
        .gnt_idx    (gnt_idx)
    );

    // Register refills in the cycle it drains; no transfer is ever reported during reset.
    always_comb begin
        load     = !out_valid_q || bus.out_ready;
        any_v    = |bus.in_valid;
        xfer     = load && any_v && !rst;
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            sel_data = sel_data | ({W{gnt[i]}} & bus.in_data[ch_lsb(i, W) +: W]);
        end
        bus.in_ready = xfer ? gnt : '0;
        out_valid_d  = load ? any_v : out_valid_q;
        out_data_d   = xfer ? sel_data : out_data_q;
        out_sel_d    = xfer ? gnt_idx : out_sel_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;

endmodule

// File: tb/tb_muxn_rr_stream.sv
// tb_muxn_rr_stream: directed and random checks of muxn_rr_stream against a behavioural model.
module tb_muxn_rr_stream;
    localparam int N = 4;
    localparam int W = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    muxn_rr_stream_if #(.N(N), .W(W)) bus ();

    muxn_rr_stream #(.N(N), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors = 0;
    int errs    = 0;

    bit          m_valid;
    logic [63:0] m_data;
    int          m_sel;
    int          m_ptr;
    logic [63:0] sb [N][$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] iv, input int p);
        int start;
`ifdef MUXN_FIXED_PRIO_EN
        start = 0;
`else
        start = p;
`endif
        for (int k = 0; k < N; k++) if (iv[(start + k) % N]) return (start + k) % N;
        return -1;
    endfunction

    function automatic logic [63:0] lane(input int i);
        return bus.in_data[i*W +: W];
    endfunction

    task automatic set_fixed_data();
        for (int i = 0; i < N; i++) bus.in_data[i*W +: W] = 64'd7 + 64'(i * 5);
    endtask

    task automatic set_rand_data();
        for (int i = 0; i < N; i++) bus.in_data[i*W +: W] = {$urandom, $urandom};
    endtask

    // One clock: drive at negedge, check handshake before the edge, outputs #1 after it.
    task automatic cycle(input logic r, input logic [N-1:0] iv, input logic ordy);
        int g;
        logic [N-1:0] exp_rdy;
        bit ld;
        rst = r;
        bus.in_valid  = iv;
        bus.out_ready = ordy;
        #1;
        ld = !m_valid || ordy;
        g  = pick(iv, m_ptr);
        exp_rdy = (!r && ld && g >= 0) ? (N'(1) << g) : '0;
        chk("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
        if (!r && bus.out_valid && ordy) begin
            chk("sb_nonempty", 64'(sb[bus.out_sel].size() != 0), 64'd1);
            if (sb[bus.out_sel].size() != 0) chk("sb_data", bus.out_data, sb[bus.out_sel].pop_front());
        end
        if (r) begin
            m_valid = 0; m_data = '0; m_sel = 0; m_ptr = 0;
            for (int i = 0; i < N; i++) sb[i].delete();
        end else if (ld) begin
            if (g >= 0) begin
                m_valid = 1; m_data = lane(g); m_sel = g; m_ptr = (g + 1) % N;
                sb[g].push_back(lane(g));
            end else m_valid = 0;
        end
        @(posedge clk);
        #1;
        chk("out_valid", 64'(bus.out_valid), 64'(m_valid));
        chk("out_data", bus.out_data, m_data);
        chk("out_sel", 64'(bus.out_sel), 64'(m_sel));
        @(negedge clk);
    endtask

    initial begin
        bus.in_valid = '0;
        bus.out_ready = 1'b0;
        bus.in_data = '0;
        m_valid = 0; m_data = '0; m_sel = 0; m_ptr = 0;
        set_fixed_data();
        @(negedge clk);
        // Reset with every channel requesting
        cycle(1, 4'b1111, 1);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        cycle(1, 4'b1111, 1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_data", bus.out_data, 64'd0);
        chk("rst_out_sel", 64'(bus.out_sel), 64'd0);
        // Single transfer from channel 1
        cycle(0, 4'b0010, 1);
        chk("single_valid", 64'(bus.out_valid), 64'd1);
        chk("single_data", bus.out_data, 64'd12);
        chk("single_sel", 64'(bus.out_sel), 64'd1);
        cycle(0, 4'b0000, 1);
        chk("drain_valid", 64'(bus.out_valid), 64'd0);
        // Rotation from ptr=0 with all channels valid
        cycle(1, 4'b0000, 1);
        for (int k = 0; k < 7; k++) begin
            cycle(0, 4'b1111, 1);
`ifdef MUXN_FIXED_PRIO_EN
            chk("rr_sel", 64'(bus.out_sel), 64'd0);
`else
            chk("rr_sel", 64'(bus.out_sel), 64'(k % N));
`endif
            chk("rr_valid", 64'(bus.out_valid), 64'd1);
        end
        // Stall holding channel 2's word
        for (int k = 0; k < 3; k++) begin
            cycle(0, 4'b1111, 0);
`ifndef MUXN_FIXED_PRIO_EN
            chk("stall_data", bus.out_data, 64'd17);
`endif
            chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
        end
        cycle(0, 4'b1111, 1);
`ifndef MUXN_FIXED_PRIO_EN
        chk("release_sel", 64'(bus.out_sel), 64'd3);
`endif
        // Reset while a word is stuck in the register
        cycle(0, 4'b1111, 0);
        cycle(1, 4'b1111, 0);
        chk("midrst_valid", 64'(bus.out_valid), 64'd0);
        cycle(0, 4'b1111, 1);
        chk("post_rst_sel", 64'(bus.out_sel), 64'd0);
        // Fixed-priority starvation pattern; round-robin alternates 1 and 3
        for (int k = 0; k < 4; k++) begin
            cycle(0, 4'b1010, 1);
`ifdef MUXN_FIXED_PRIO_EN
            chk("fixed_sel", 64'(bus.out_sel), 64'd1);
`else
            chk("alt_sel", 64'(bus.out_sel), (k % 2 == 0) ? 64'd1 : 64'd3);
`endif
        end
        // Random traffic with occasional resets
        for (int k = 0; k < 400; k++) begin
            set_rand_data();
            cycle(($urandom_range(0, 59) == 0), N'($urandom), ($urandom_range(0, 3) != 0));
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
